// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: IDLE/FETCH/DECODE/EXECUTE/MEM/WB/HALT/ERROR control FSM.
// Latency: 4 cycles per non-memory instruction plus handshake waits; outputs decoded from state.
// Backpressure: FETCH and MEM stall on imem_ack/dmem_ack, bounded by TIMEOUT before ERROR.
module core_sequencer #(
    parameter int OP_LEN  = 7,
    parameter int CNT_LEN = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt_req,
    input  logic [OP_LEN-1:0]  opcode,
    input  logic               jal,
    input  logic               jalr,
    input  logic               branch,
    input  logic               load,
    input  logic               store,
    input  logic               lui,
    input  logic               auipc,
    input  logic               arith,
    output logic               imem_req,
    input  logic               imem_ack,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               ir_we,
    output logic               dec_en,
    output logic               exe_en,
    output logic               rf_we,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic [2:0]         state,
    output logic               busy,
    output logic               illegal,
    output logic [CNT_LEN-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     cur;
    logic [7:0] wait_cnt;
    logic       halt_pend;
    logic       lat_jal, lat_jalr, lat_branch, lat_store, lat_brop;
    logic       op_legal;
    logic       unused_flags;

    // Class flags below are decoded elsewhere; the sequencer only needs the opcode check.
    assign unused_flags = ^{lui, auipc, arith};

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_LEN'(7'b1101111), OP_LEN'(7'b1100111), OP_LEN'(7'b1100011),
            OP_LEN'(7'b0000011), OP_LEN'(7'b0100011), OP_LEN'(7'b0110111),
            OP_LEN'(7'b0010111), OP_LEN'(7'b0010011), OP_LEN'(7'b0110011): op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= S_IDLE;
            wait_cnt    <= 8'd0;
            retired_cnt <= '0;
            illegal     <= 1'b0;
            halt_pend   <= 1'b0;
            lat_jal     <= 1'b0;
            lat_jalr    <= 1'b0;
            lat_branch  <= 1'b0;
            lat_store   <= 1'b0;
            lat_brop    <= 1'b0;
        end else begin
            if (halt_req && cur inside {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB})
                halt_pend <= 1'b1;
            case (cur)
                S_IDLE: begin
                    wait_cnt <= 8'd0;
                    if (start) cur <= S_FETCH;
                end
                S_FETCH: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (imem_ack) begin
                        cur      <= S_DECODE;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        cur      <= S_ERROR;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (op_legal) begin
                        cur <= S_EXECUTE;
                    end else begin
                        illegal <= 1'b1;
                        cur     <= S_ERROR;
                    end
                end
                S_EXECUTE: begin
                    lat_jal    <= jal;
                    lat_jalr   <= jalr;
                    lat_branch <= branch;
                    lat_store  <= store;
                    lat_brop   <= (opcode == OP_LEN'(7'b1100011));
                    wait_cnt   <= 8'd0;
                    cur        <= (load || store) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        cur      <= S_WB;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        cur      <= S_ERROR;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    retired_cnt <= retired_cnt + CNT_LEN'(1);
                    wait_cnt    <= 8'd0;
                    if (halt_pend || halt_req) begin
                        cur       <= S_HALT;
                        halt_pend <= 1'b0;
                    end else begin
                        cur <= S_FETCH;
                    end
                end
                S_HALT: begin
                    wait_cnt <= 8'd0;
                    if (start) cur <= S_FETCH;
                end
                default: cur <= S_ERROR;
            endcase
        end
    end

    always_comb begin
        imem_req = (cur == S_FETCH);
        ir_we    = (cur == S_FETCH) && imem_ack;
        dec_en   = (cur == S_DECODE);
        exe_en   = (cur == S_EXECUTE);
        dmem_req = (cur == S_MEM);
        dmem_we  = (cur == S_MEM) && lat_store;
        pc_we    = (cur == S_WB);
        rf_we    = (cur == S_WB) && !(lat_store || lat_brop);
        pc_sel   = 2'd0;
        if (cur == S_WB) begin
            if (lat_jal)         pc_sel = 2'd1;
            else if (lat_jalr)   pc_sel = 2'd2;
            else if (lat_branch) pc_sel = 2'd3;
        end
        busy  = cur inside {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB};
        state = cur;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Parameters
REQ-001 SHALL have parameter OP_LEN, default 7: opcode width.
REQ-002 SHALL have parameter CNT_LEN, default 32: retired-instruction counter width.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum memory wait in cycles, legal range 2..255.

Interface
REQ-004 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: begin or resume execution.
REQ-007 SHALL have port halt_req, input, 1 bit: request a stop after the current instruction retires.
REQ-008 SHALL have port opcode, input, OP_LEN bits: opcode of the instruction register, valid in DECODE.
REQ-009 SHALL have ports jal, jalr, branch, load, store, lui, auipc and arith, input, 1 bit each: decode class flags; branch=1 means taken.
REQ-010 SHALL have port imem_req, output, 1 bit, and port imem_ack, input, 1 bit: instruction-fetch handshake.
REQ-011 SHALL have ports dmem_req and dmem_we, output, 1 bit each, and port dmem_ack, input, 1 bit: data-memory handshake.
REQ-012 SHALL have ports ir_we, dec_en, exe_en, rf_we and pc_we, output, 1 bit each: stage enables.
REQ-013 SHALL have port pc_sel, output, 2 bits: next-PC select; 0=pc+4, 1=pc+imm_j, 2=rs1+imm_i, 3=pc+imm_b.
REQ-014 SHALL have ports state, output, 3 bits; busy, output, 1 bit; illegal, output, 1 bit (sticky); retired_cnt, output, CNT_LEN bits.

Function
REQ-015 SHALL encode states as IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6, ERROR=7, and SHALL drive the state port from the state register.
REQ-016 SHALL decode every output combinationally from the registered state (Moore), except ir_we.
REQ-017 SHALL, in IDLE, move to FETCH when start=1 and otherwise stay in IDLE; halt_req SHALL be ignored in IDLE.
REQ-018 SHALL, in FETCH, hold imem_req=1 and assert ir_we=imem_ack (Mealy), then move to DECODE on the cycle after imem_ack=1.
REQ-019 SHALL, in DECODE, assert dec_en=1 for exactly one cycle and then move to EXECUTE; if opcode is not one of 1101111, 1100111, 1100011, 0000011, 0100011, 0110111, 0010111, 0010011 or 0110011, it SHALL set illegal=1 and move to ERROR instead.
REQ-020 SHALL, in EXECUTE, assert exe_en=1 for one cycle, then move to MEM if load or store is 1, else to WB.
REQ-021 SHALL, in MEM, hold dmem_req=1 with dmem_we=store, registered at EXECUTE exit, and move to WB on the cycle after dmem_ack=1.
REQ-022 SHALL use a wait counter that clears on entry to FETCH or MEM; if TIMEOUT cycles elapse in that state without an ack, the state SHALL become ERROR.
REQ-023 SHALL give an ack priority when the ack and the timeout occur in the same cycle.
REQ-024 SHALL latch the EXECUTE-cycle flags (jal, jalr, branch, store, and branch-opcode) for use in WB.
REQ-025 SHALL, in WB, assert pc_we=1 for one cycle.
REQ-026 SHALL, in WB, assert rf_we=1 unless the instruction is a store or has opcode 1100011.
REQ-027 SHALL, in WB, drive pc_sel=1 if jal, else 2 if jalr, else 3 if branch is taken, else 0.
REQ-028 SHALL, in WB, increment retired_cnt by 1, wrapping from all-ones to 0.
REQ-029 SHALL set halt_pend on halt_req=1 in any state FETCH..WB, and at WB exit SHALL move to HALT if halt_pend or halt_req is set, else to FETCH; halt_pend SHALL clear on entering HALT.
REQ-030 SHALL, in HALT, move to FETCH when start=1, with retired_cnt preserved.
REQ-031 SHALL hold ERROR until rst; start SHALL be ignored in ERROR.
REQ-032 SHALL drive busy=1 in the states FETCH..WB, else 0.
REQ-033 SHALL keep all outputs other than state, busy, illegal and retired_cnt at 0 outside their owning state.

Reset
REQ-034 SHALL, while rst=1 at a clock edge, set the state to IDLE and clear retired_cnt, wait counter, illegal, halt_pend and latched flags to 0.
REQ-035 SHALL give rst priority over every other input.
REQ-036 SHALL, on rst in mid-transaction, drop imem_req or dmem_req in the first cycle after the reset edge and discard the instruction without retiring it.

Verification
REQ-037 SHALL cover: rst, then start with opcode 0110011 (arith) and imem_ack in the first FETCH cycle -> state 1,2,3,5,1; WB rf_we=1, pc_we=1, pc_sel=0; retired_cnt=1.
REQ-038 SHALL cover: a load with dmem_ack delayed 3 cycles -> MEM lasts 4 cycles with dmem_we=0, then WB rf_we=1; a store -> dmem_we=1, WB rf_we=0, pc_sel=0.
REQ-039 SHALL cover: opcode 1100011 with branch=1 -> WB pc_sel=3, rf_we=0; with branch=0 -> pc_sel=0; jal -> pc_sel=1, rf_we=1; jalr -> pc_sel=2, rf_we=1.
REQ-040 SHALL cover: opcode 0000000 -> ERROR with illegal=1, no retire, and start ignored until rst; no imem_ack with TIMEOUT=16 -> ERROR after exactly 16 FETCH cycles.
REQ-041 SHALL cover: a 1-cycle halt_req pulse in EXECUTE -> WB, then HALT, with busy=0; start -> FETCH with retired_cnt continuing.
REQ-042 SHALL cover: rst in MEM with dmem_req=1 -> IDLE next cycle, dmem_req=0, retired_cnt=0; and retired_cnt wrap with CNT_LEN=4 -> 15 then 0.
